apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Sequences the APB master's bridge-side controls (transfer/read/write, addresses, data, strobes) and shares it between two requesters: an AXI write-channel requester (W) and an AXI read-channel requester (R).
- Arbitrates round-robin, issues one APB transaction at a time and tracks completion via a completion pulse from the bus.
- Enforces a timeout and returns a done/error response to the granted requester.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT, 16, max cycles from transfer assertion to xfer_done before abort (>=2).
- TO_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- PCLK  in  1  clock, all logic rising-edge.
- PRESET  in  1  asynchronous, active-high reset.
- wr_req  in  1  W request, level; held with wr_addr/wr_data/wr_strb until wr_done.
- wr_addr  in  ADDR_WIDTH  W address.
- wr_data  in  DATA_WIDTH  W data.
- wr_strb  in  4  W byte strobes.
- wr_done  out  1  one-cycle W completion pulse.
- wr_err  out  1  error qualifier, valid only with wr_done.
- rd_req  in  1  R request, level; held with rd_addr until rd_done.
- rd_addr  in  ADDR_WIDTH  R address.
- rd_done  out  1  one-cycle R completion pulse.
- rd_err  out  1  error qualifier, valid only with rd_done.
- rd_data  out  DATA_WIDTH  read data, valid with rd_done.
- transfer  out  1  to APB master.
- read  out  1  to APB master.
- write  out  1  to APB master.
- WSTRB  out  4  to APB master.
- apb_waddr  out  ADDR_WIDTH  to APB master.
- apb_raddr  out  ADDR_WIDTH  to APB master.
- apb_wdata  out  DATA_WIDTH  to APB master.
- apb_rdata  in  DATA_WIDTH  from APB master.
- xfer_done  in  1  one-cycle pulse on the access-phase cycle with PENABLE & PREADY.
- error  in  1  PSLVERR from the APB master, sampled with xfer_done.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset state, all outputs: state IDLE; every output 0; last_grant=R, so W wins the first tie.
- IDLE:
  - Arbitrate on wr_req/rd_req.
  - Single requester wins.
  - If both request, the one not equal to last_grant wins.
  - Winner is registered into grant and last_grant; address/data/strobe are captured into internal registers.
  - Next state ISSUE.
- ISSUE (one cycle):
  - transfer=1.
  - write=1,read=0 for W; read=1,write=0 for R.
  - Captured values drive apb_waddr/apb_wdata/WSTRB (W) or apb_raddr (R); the unused address/data outputs are 0.
  - Timeout counter cleared to 0.
  - Next state WAIT.
- WAIT:
  - transfer/read/write/address/data held stable.
  - Counter increments each cycle.
  - On xfer_done: capture error, and capture apb_rdata if grant=R; go RESP.
  - Else if counter reaches TIMEOUT-1: set err=1, rdata=0, deassert transfer; go RESP.
  - xfer_done and timeout in the same cycle: xfer_done wins (no error unless error=1).
- RESP (one cycle):
  - transfer/read/write=0.
  - Pulse wr_done or rd_done for the granted side with the corresponding err; rd_data valid for R only and otherwise 0.
  - Next state IDLE.
- Minimum latency: req seen in IDLE at cycle 0 → transfer at cycle 1; xfer_done at cycle k → done at cycle k+1.
- Back-to-back:
  - A requester must drop req the cycle after its done; a req still high in IDLE is treated as a new transaction.
  - No starvation: with both requests continuously high, grants alternate W,R,W,R.
- xfer_done or error outside WAIT: ignored.
- Request withdrawn after grant: ignored; the transaction completes on the captured values.
- PRESET asserted mid-transaction: immediate return to IDLE, all outputs 0 in the same cycle (async); no done is emitted for the aborted transaction.

Test Plan:
- Single write: wr_req, addr=0x0000_0010, data=0xDEAD_BEEF, strb=0xF; xfer_done 3 cycles after transfer → transfer high 4 cycles, write=1, apb_waddr=0x10, apb_wdata=0xDEADBEEF, then wr_done=1, wr_err=0 one cycle; busy=0 after.
- Single read: rd_req, addr=0x0000_0004; apb_rdata=0x1234_5678 with xfer_done → rd_done pulse with rd_data=0x12345678, rd_err=0; read=1,write=0 throughout.
- Contention from reset: wr_req and rd_req both rise in the same cycle and stay high → grant order W,R,W,R across four transactions; never two consecutive grants to the same side.
- Slave error: read with error=1 on xfer_done → rd_err=1 with rd_done; the next transaction has no error.
- Timeout: write with xfer_done never asserted → transfer deasserts after 16 cycles; wr_done=1, wr_err=1 next cycle; a later stray xfer_done is ignored.
- Reset mid-WAIT: assert PRESET 2 cycles after transfer → transfer, busy, and done outputs 0 immediately; after release, a pending rd_req and wr_req together are granted W first.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
// Shares one APB master between an AXI write-channel requester (W) and an
// AXI read-channel requester (R). Requests are arbitrated round-robin, one
// APB transaction is in flight at a time, and each transaction either
// completes on the bus completion pulse or is aborted by a timeout. The
// granted requester receives a one-cycle done pulse with an error qualifier.
//
// Ports:
//   PCLK, PRESET          clock (rising edge) and async active-high reset
//   wr_req/addr/data/strb W request, held until wr_done
//   wr_done, wr_err       W completion pulse and error qualifier
//   rd_req, rd_addr       R request, held until rd_done
//   rd_done, rd_err       R completion pulse and error qualifier
//   rd_data               read data, valid with rd_done
//   transfer/read/write   bridge controls to the APB master
//   WSTRB, apb_waddr,
//   apb_raddr, apb_wdata  bridge address/data/strobes to the APB master
//   apb_rdata             read data from the APB master
//   xfer_done, error      access-phase completion pulse and PSLVERR
//   busy                  high whenever the arbiter is not idle

module apb_req_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16,
  parameter int TO_W       = 5
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [3:0]            wr_strb,
  output logic                  wr_done,
  output logic                  wr_err,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  transfer,
  output logic                  read,
  output logic                  write,
  output logic [3:0]            WSTRB,
  output logic [ADDR_WIDTH-1:0] apb_waddr,
  output logic [ADDR_WIDTH-1:0] apb_raddr,
  output logic [DATA_WIDTH-1:0] apb_wdata,
  input  logic [DATA_WIDTH-1:0] apb_rdata,
  input  logic                  xfer_done,
  input  logic                  error,
  output logic                  busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic GRANT_W = 1'b0;
  localparam logic GRANT_R = 1'b1;

  // Value the incremented counter hits on the last cycle transfer may stay
  // high, so transfer is asserted for exactly TIMEOUT cycles on an abort.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]            r_state;
  logic                  r_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_strb;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [TO_W-1:0]       r_cnt;

  logic [TO_W-1:0]       w_cntNext;
  logic                  w_timeout;
  logic                  w_pickW;
  logic                  w_active;
  logic                  w_grantW;
  logic                  w_resp;

  // r_grant doubles as last_grant: it keeps the previous winner while idle,
  // so on a tie the side that did not win last time is picked. Resetting it
  // to R lets W win the first tie.
  assign w_pickW   = wr_req && (!rd_req || (r_grant == GRANT_R));
  assign w_cntNext = r_cnt + TO_W'(1);
  assign w_timeout = (w_cntNext == TO_LAST);

  // Transaction sequencer. Request values are captured on grant so that a
  // requester changing or withdrawing its inputs afterwards has no effect.
  // xfer_done and error are only looked at in WAIT, and a completion in the
  // same cycle as the timeout takes priority over the abort.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_grant <= GRANT_R;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (wr_req || rd_req) begin
            r_grant <= w_pickW ? GRANT_W : GRANT_R;
            r_addr  <= w_pickW ? wr_addr : rd_addr;
            r_wdata <= w_pickW ? wr_data : '0;
            r_strb  <= w_pickW ? wr_strb : 4'h0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_err   <= 1'b0;
          r_rdata <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= w_cntNext;
          if (xfer_done) begin
            r_err   <= error;
            r_rdata <= (r_grant == GRANT_R) ? apb_rdata : '0;
            r_state <= RESP;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // All outputs decode from the state registers, so an asynchronous reset
  // clears them in the same cycle without waiting for a clock edge. Bus
  // address/data outputs are forced to zero whenever they are not in use.
  assign w_active = (r_state == ISSUE) || (r_state == WAIT);
  assign w_grantW = (r_grant == GRANT_W);
  assign w_resp   = (r_state == RESP);

  assign transfer  = w_active;
  assign write     = w_active && w_grantW;
  assign read      = w_active && !w_grantW;
  assign apb_waddr = (w_active && w_grantW)  ? r_addr  : '0;
  assign apb_wdata = (w_active && w_grantW)  ? r_wdata : '0;
  assign WSTRB     = (w_active && w_grantW)  ? r_strb  : 4'h0;
  assign apb_raddr = (w_active && !w_grantW) ? r_addr  : '0;

  assign wr_done = w_resp && w_grantW;
  assign wr_err  = w_resp && w_grantW && r_err;
  assign rd_done = w_resp && !w_grantW;
  assign rd_err  = w_resp && !w_grantW && r_err;
  assign rd_data = (w_resp && !w_grantW) ? r_rdata : '0;

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter
// Self-checking bench for apb_req_arbiter. Each scenario is a task; a
// transaction-level model predicts the winner, how many cycles transfer is
// high, and the completion response, and every cycle of each transaction is
// compared against that prediction.

module tb_apb_req_arbiter;

  localparam int TIMEOUT = 16;

  logic        PCLK;
  logic        PRESET;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_done;
  logic        wr_err;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_done;
  logic        rd_err;
  logic [31:0] rd_data;
  logic        transfer;
  logic        read;
  logic        write;
  logic [3:0]  WSTRB;
  logic [31:0] apb_waddr;
  logic [31:0] apb_raddr;
  logic [31:0] apb_wdata;
  logic [31:0] apb_rdata;
  logic        xfer_done;
  logic        error;
  logic        busy;

  int nChecks = 0;
  int nFails  = 0;
  bit mLastW;
  bit obsGrant[$];

  apb_req_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(TIMEOUT),
    .TO_W(5)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_done(wr_done), .wr_err(wr_err),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_err(rd_err), .rd_data(rd_data),
    .transfer(transfer), .read(read), .write(write), .WSTRB(WSTRB),
    .apb_waddr(apb_waddr), .apb_raddr(apb_raddr), .apb_wdata(apb_wdata),
    .apb_rdata(apb_rdata), .xfer_done(xfer_done), .error(error), .busy(busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance to 1 time unit after the next rising edge: outputs are observed
  // here and inputs for the following edge are driven here.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESET    = 1'b1;
    wr_req    = 1'b0;
    rd_req    = 1'b0;
    xfer_done = 1'b0;
    error     = 1'b0;
    apb_rdata = '0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    mLastW = 1'b0;
  endtask

  // One transaction from the IDLE cycle in which requests are visible to the
  // IDLE cycle after completion. d is the number of cycles after transfer
  // rises at which the slave pulses xfer_done (negative: never).
  task automatic txn(input string tag, input int d, input bit slvErr,
                     input logic [31:0] slvData, input bit scramble);
    bit          isW;
    bit          eTo;
    bit          eErr;
    int          nHigh;
    logic [31:0] eAddr;
    logic [31:0] eData;
    logic [3:0]  eStrb;
    logic [31:0] eRdata;

    if (wr_req && rd_req) isW = !mLastW;
    else                  isW = wr_req;
    mLastW = isW;
    eAddr  = isW ? wr_addr : rd_addr;
    eData  = isW ? wr_data : 32'h0;
    eStrb  = isW ? wr_strb : 4'h0;
    eTo    = !(d >= 1 && d <= TIMEOUT - 1);
    nHigh  = eTo ? TIMEOUT : d + 1;
    eErr   = eTo ? 1'b1 : slvErr;
    eRdata = (!isW && !eTo) ? slvData : 32'h0;

    for (int cyc = 0; cyc < nHigh; cyc++) begin
      step();
      if (cyc == 0) obsGrant.push_back(write);
      nChecks++;
      if (transfer !== 1'b1 || write !== isW || read !== !isW ||
          apb_waddr !== (isW ? eAddr : 32'h0) || apb_raddr !== (isW ? 32'h0 : eAddr) ||
          apb_wdata !== eData || WSTRB !== eStrb || busy !== 1'b1 ||
          wr_done !== 1'b0 || rd_done !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL %s active cyc%0d: got xfer=%b wr=%b rd=%b waddr=%h raddr=%h wdata=%h strb=%h busy=%b done=%b%b, want xfer=1 wr=%b rd=%b waddr=%h raddr=%h wdata=%h strb=%h busy=1 done=00",
                 tag, cyc, transfer, write, read, apb_waddr, apb_raddr, apb_wdata, WSTRB,
                 busy, wr_done, rd_done, isW, !isW, isW ? eAddr : 32'h0,
                 isW ? 32'h0 : eAddr, eData, eStrb);
      end
      if (scramble && cyc == 0) begin
        if (isW) begin
          wr_addr = $urandom; wr_data = $urandom; wr_strb = 4'($urandom); wr_req = 1'($urandom);
        end else begin
          rd_addr = $urandom; rd_req = 1'($urandom);
        end
      end
      if (cyc == d) begin
        xfer_done = 1'b1; error = slvErr; apb_rdata = slvData;
      end else begin
        xfer_done = 1'b0; error = 1'($urandom); apb_rdata = $urandom;
      end
    end

    step();
    nChecks++;
    if (transfer !== 1'b0 || write !== 1'b0 || read !== 1'b0 || busy !== 1'b1 ||
        wr_done !== isW || rd_done !== !isW ||
        wr_err !== (isW & eErr) || rd_err !== (!isW & eErr) || rd_data !== eRdata) begin
      nFails++;
      $display("[TB] FAIL %s response: got xfer=%b wr=%b rd=%b busy=%b wr_done=%b wr_err=%b rd_done=%b rd_err=%b rd_data=%h, want xfer=0 wr=0 rd=0 busy=1 wr_done=%b wr_err=%b rd_done=%b rd_err=%b rd_data=%h",
               tag, transfer, write, read, busy, wr_done, wr_err, rd_done, rd_err, rd_data,
               isW, isW & eErr, !isW, !isW & eErr, eRdata);
    end
    if (isW) wr_req = 1'b0;
    else     rd_req = 1'b0;
    xfer_done = 1'($urandom);
    error     = 1'($urandom);
    apb_rdata = $urandom;

    step();
    nChecks++;
    if (busy !== 1'b0 || transfer !== 1'b0 || wr_done !== 1'b0 || rd_done !== 1'b0 ||
        rd_data !== 32'h0 || apb_waddr !== 32'h0 || apb_raddr !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL %s idle after done: got busy=%b xfer=%b done=%b%b rd_data=%h waddr=%h raddr=%h, want all 0",
               tag, busy, transfer, wr_done, rd_done, rd_data, apb_waddr, apb_raddr);
    end
    xfer_done = 1'b0;
    error     = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    wr_addr = 32'hFFFF_FFFF; wr_data = 32'hFFFF_FFFF; wr_strb = 4'hF;
    rd_addr = 32'hFFFF_FFFF;
    xfer_done = 1'b1; error = 1'b1; apb_rdata = 32'hFFFF_FFFF;
    step();
    step();
    nChecks++;
    if (busy !== 1'b0 || transfer !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset controls: got busy=%b xfer=%b rd=%b wr=%b, want 0000",
               busy, transfer, read, write);
    end
    nChecks++;
    if (wr_done !== 1'b0 || wr_err !== 1'b0 || rd_done !== 1'b0 || rd_err !== 1'b0 ||
        rd_data !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL reset responses: got wr_done=%b wr_err=%b rd_done=%b rd_err=%b rd_data=%h, want 0",
               wr_done, wr_err, rd_done, rd_err, rd_data);
    end
    nChecks++;
    if (apb_waddr !== 32'h0 || apb_raddr !== 32'h0 || apb_wdata !== 32'h0 || WSTRB !== 4'h0) begin
      nFails++;
      $display("[TB] FAIL reset buses: got waddr=%h raddr=%h wdata=%h strb=%h, want 0",
               apb_waddr, apb_raddr, apb_wdata, WSTRB);
    end
    wr_req = 1'b0; rd_req = 1'b0; xfer_done = 1'b0; error = 1'b0;
    PRESET = 1'b0;
    mLastW = 1'b0;
    step();
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL idle without request: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    wr_addr = 32'h0000_0010; wr_data = 32'hDEAD_BEEF; wr_strb = 4'hF;
    wr_req  = 1'b1;
    txn("single_write", 3, 1'b0, $urandom, 1'b0);
  endtask

  task automatic test_single_read();
    do_reset();
    rd_addr = 32'h0000_0004;
    rd_req  = 1'b1;
    txn("single_read", 2, 1'b0, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_contention();
    do_reset();
    obsGrant.delete();
    wr_addr = 32'h0000_0100; wr_data = 32'hA5A5_0001; wr_strb = 4'h3;
    rd_addr = 32'h0000_0200;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      txn("contention", int'($urandom_range(1, 5)), 1'b0, $urandom, 1'b0);
      wr_req = 1'b1;
      rd_req = 1'b1;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (obsGrant.size() <= i || obsGrant[i] !== ((i % 2) == 0)) begin
        nFails++;
        $display("[TB] FAIL contention grant %0d: got write=%b, want %b", i,
                 (obsGrant.size() > i) ? obsGrant[i] : 1'bx, (i % 2) == 0);
      end
    end
    step();
  endtask

  task automatic test_slave_error();
    do_reset();
    rd_addr = 32'h0000_0040;
    rd_req  = 1'b1;
    txn("slave_error", 2, 1'b1, 32'hCAFE_F00D, 1'b0);
    rd_addr = 32'h0000_0044;
    rd_req  = 1'b1;
    txn("after_error", 1, 1'b0, 32'h0BAD_CAFE, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    wr_addr = 32'h0000_0080; wr_data = 32'h5555_AAAA; wr_strb = 4'h9;
    wr_req  = 1'b1;
    txn("timeout", -1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      xfer_done = 1'b1; error = 1'b1;
      step();
      nChecks++;
      if (busy !== 1'b0 || wr_done !== 1'b0 || rd_done !== 1'b0 || transfer !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL stray xfer_done %0d: got busy=%b xfer=%b done=%b%b, want 0",
                 i, busy, transfer, wr_done, rd_done);
      end
    end
    xfer_done = 1'b0; error = 1'b0;
    wr_addr = 32'h0000_0084; wr_req = 1'b1;
    txn("timeout_boundary", TIMEOUT - 1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    rd_addr = 32'h0000_0300;
    rd_req  = 1'b1;
    repeat (3) step();
    nChecks++;
    if (transfer !== 1'b1 || read !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL pre-reset wait: got xfer=%b rd=%b, want 1 1", transfer, read);
    end
    wr_addr = 32'h0000_0400; wr_data = 32'h0F0F_0F0F; wr_strb = 4'hC;
    wr_req  = 1'b1;
    PRESET  = 1'b1;
    #1;
    nChecks++;
    if (transfer !== 1'b0 || read !== 1'b0 || busy !== 1'b0 || apb_raddr !== 32'h0 ||
        rd_done !== 1'b0 || wr_done !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL async reset: got xfer=%b rd=%b busy=%b raddr=%h done=%b%b, want 0",
               transfer, read, busy, apb_raddr, rd_done, wr_done);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      nChecks++;
      if (rd_done !== 1'b0 || wr_done !== 1'b0 || busy !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL held reset %0d: got done=%b%b busy=%b, want 0", i, rd_done, wr_done, busy);
      end
    end
    PRESET = 1'b0;
    mLastW = 1'b0;
    obsGrant.delete();
    txn("post_reset_first", 2, 1'b0, $urandom, 1'b0);
    nChecks++;
    if (obsGrant.size() != 1 || obsGrant[0] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL post-reset grant: got write=%b, want 1",
               (obsGrant.size() > 0) ? obsGrant[0] : 1'bx);
    end
    rd_req = 1'b0;
    step();
  endtask

  task automatic test_random();
    int d;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if (!wr_req && ($urandom_range(0, 9) < 6)) begin
        wr_req = 1'b1; wr_addr = $urandom; wr_data = $urandom; wr_strb = 4'($urandom);
      end
      if (!rd_req && ($urandom_range(0, 9) < 6)) begin
        rd_req = 1'b1; rd_addr = $urandom;
      end
      if (!wr_req && !rd_req) begin
        wr_req = 1'b1; wr_addr = $urandom; wr_data = $urandom; wr_strb = 4'($urandom);
      end
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 2));
      txn("random", d, 1'($urandom), $urandom, 1'($urandom));
    end
    wr_req = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; wr_strb = '0; rd_addr = '0;
    xfer_done = 1'b0; error = 1'b0; apb_rdata = '0;
    mLastW = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_slave_error();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
